// File: rtl/rvv_backend_dispatch_sb_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rvv_backend_dispatch_sb_ctrl_pkg
// Brief   : Shared dispatch types and constants for the vreg write scoreboard.
// Rev     : 1.0
// ============================================================================
`ifndef V0_INDEX
`define V0_INDEX 5'd0
`endif

package rvv_backend_dispatch_sb_ctrl_pkg;

   localparam int NUM_VREG   = 32;
   localparam int VREG_IDX_W = 5;
   localparam logic [VREG_IDX_W-1:0] V0_IDX = `V0_INDEX;

   typedef struct packed {
      logic [VREG_IDX_W-1:0] vs1_index;
      logic [VREG_IDX_W-1:0] vs2_index;
      logic [VREG_IDX_W-1:0] vd_index;
      logic                  vs1_valid;
      logic                  vs2_valid;
      logic                  vs3_valid;
      logic                  vm;
      logic                  vd_valid;
   } SB_UOP_t;

endpackage
`default_nettype wire

// File: rtl/rvv_backend_dispatch_sb_cnt.sv
`default_nettype none
// ============================================================================
// Module  : rvv_backend_dispatch_sb_cnt
// Brief   : Pending-writer counter for one vreg. RVV_SB_RETIRE_BYPASS_EN makes
//           the hazard-facing count subtract same-cycle retires.
// Rev     : 1.0
// ============================================================================
module rvv_backend_dispatch_sb_cnt #(
   parameter int CNT_W = 3,
   parameter int INC_W = 2,
   parameter int DEC_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_flush,
   input  logic [INC_W-1:0] i_inc,
   input  logic [DEC_W-1:0] i_dec,
   output logic [CNT_W-1:0] o_cnt_eff,
   output logic             o_busy,
   output logic             o_pending,
   output logic             o_underflow
);

   localparam int SUM_W = CNT_W + INC_W + DEC_W;
   localparam logic [SUM_W-1:0] MAX_CNT = SUM_W'((1 << CNT_W) - 1);

   logic [CNT_W-1:0] r_cnt;
   logic [SUM_W-1:0] w_up;
   logic [SUM_W-1:0] w_dn;
   logic [SUM_W-1:0] w_net;
   logic             w_under;

   assign w_up    = SUM_W'(r_cnt) + SUM_W'(i_inc);
   assign w_dn    = SUM_W'(i_dec);
   assign w_under = (w_dn > w_up);
   assign w_net   = w_under ? '0 : (w_up - w_dn);

   assign o_underflow = ~i_flush & w_under;

   // The dispatch gate never lets the count exceed MAX; the clamp is a backstop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_flush) begin
         r_cnt <= '0;
      end else if (w_net > MAX_CNT) begin
         r_cnt <= '1;
      end else begin
         r_cnt <= CNT_W'(w_net);
      end
   end

`ifdef RVV_SB_RETIRE_BYPASS_EN
   assign o_cnt_eff = (w_dn >= SUM_W'(r_cnt)) ? '0 : CNT_W'(SUM_W'(r_cnt) - w_dn);
`else
   assign o_cnt_eff = r_cnt;
`endif

   assign o_busy    = |o_cnt_eff;
   assign o_pending = |r_cnt;

endmodule
`default_nettype wire

// File: rtl/rvv_backend_dispatch_sb_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : rvv_backend_dispatch_sb_ctrl
// Brief   : Vreg write scoreboard and in-order dispatch gate. Optional
//           same-cycle retire release via RVV_SB_RETIRE_BYPASS_EN.
// Rev     : 1.0
// ============================================================================
module rvv_backend_dispatch_sb_ctrl
   import rvv_backend_dispatch_sb_ctrl_pkg::*;
#(
   parameter int DISP_NUM   = 2,
   parameter int RETIRE_NUM = 4,
   parameter int CNT_W      = 3
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   i_flush,
   input  logic [DISP_NUM-1:0]                    i_disp_valid,
   input  SB_UOP_t [DISP_NUM-1:0]                 i_disp_uop,
   output logic [DISP_NUM-1:0]                    o_disp_ready,
   input  logic [RETIRE_NUM-1:0]                  i_retire_valid,
   input  logic [RETIRE_NUM-1:0][VREG_IDX_W-1:0]  i_retire_vd_index,
   output logic [NUM_VREG-1:0]                    o_pending_mask,
   output logic                                   o_sb_err
);

   localparam int INC_W = $clog2(DISP_NUM + 1);
   localparam int DEC_W = $clog2(RETIRE_NUM + 1);
   localparam int SAT_W = CNT_W + INC_W;
   localparam logic [SAT_W-1:0] MAX_CNT = SAT_W'((1 << CNT_W) - 1);

   logic [CNT_W-1:0]    w_cnt_eff [NUM_VREG];
   logic [INC_W-1:0]    w_inc     [NUM_VREG];
   logic [DEC_W-1:0]    w_dec     [NUM_VREG];
   logic [NUM_VREG-1:0] w_busy;
   logic [NUM_VREG-1:0] w_underflow;
   logic [DISP_NUM-1:0] w_accept;
   logic                r_sb_err;

   function automatic logic reads_vreg(input SB_UOP_t u, input logic [VREG_IDX_W-1:0] r);
      return (u.vs1_valid && (u.vs1_index == r)) ||
             (u.vs2_valid && (u.vs2_index == r)) ||
             (u.vs3_valid && (u.vd_index  == r)) ||
             (!u.vm       && (r == V0_IDX));
   endfunction

   always_comb begin
      logic             w_haz;
      logic             w_sat;
      logic             w_prev;
      logic [INC_W-1:0] w_older;
      o_disp_ready = '0;
      w_prev       = 1'b1;
      for (int i = 0; i < DISP_NUM; i++) begin
         w_haz   = (i_disp_uop[i].vs1_valid & w_busy[i_disp_uop[i].vs1_index]) |
                   (i_disp_uop[i].vs2_valid & w_busy[i_disp_uop[i].vs2_index]) |
                   (i_disp_uop[i].vs3_valid & w_busy[i_disp_uop[i].vd_index])  |
                   (~i_disp_uop[i].vm       & w_busy[V0_IDX]);
         w_older = '0;
         // Older writers in the same group are not yet in the counters.
         for (int j = 0; j < i; j++) begin
            if (i_disp_valid[j] && i_disp_uop[j].vd_valid) begin
               if (reads_vreg(i_disp_uop[i], i_disp_uop[j].vd_index)) begin
                  w_haz = 1'b1;
               end
               if (i_disp_uop[j].vd_index == i_disp_uop[i].vd_index) begin
                  w_older = w_older + INC_W'(1);
               end
            end
         end
         w_sat = i_disp_uop[i].vd_valid &
                 ((SAT_W'(w_cnt_eff[i_disp_uop[i].vd_index]) + SAT_W'(w_older)) >= MAX_CNT);
         o_disp_ready[i] = ~i_flush & ~w_haz & ~w_sat & w_prev;
         w_prev          = o_disp_ready[i];
      end
   end

   assign w_accept = i_disp_valid & o_disp_ready;

   always_comb begin
      for (int r = 0; r < NUM_VREG; r++) begin
         w_inc[r] = '0;
         w_dec[r] = '0;
         for (int i = 0; i < DISP_NUM; i++) begin
            if (w_accept[i] && i_disp_uop[i].vd_valid &&
                (i_disp_uop[i].vd_index == VREG_IDX_W'(r))) begin
               w_inc[r] = w_inc[r] + INC_W'(1);
            end
         end
         for (int k = 0; k < RETIRE_NUM; k++) begin
            if (!i_flush && i_retire_valid[k] &&
                (i_retire_vd_index[k] == VREG_IDX_W'(r))) begin
               w_dec[r] = w_dec[r] + DEC_W'(1);
            end
         end
      end
   end

   for (genvar r = 0; r < NUM_VREG; r++) begin : g_cnt
      rvv_backend_dispatch_sb_cnt #(
         .CNT_W (CNT_W),
         .INC_W (INC_W),
         .DEC_W (DEC_W)
      ) u_cnt (
         .clk         (clk),
         .rst         (rst),
         .i_flush     (i_flush),
         .i_inc       (w_inc[r]),
         .i_dec       (w_dec[r]),
         .o_cnt_eff   (w_cnt_eff[r]),
         .o_busy      (w_busy[r]),
         .o_pending   (o_pending_mask[r]),
         .o_underflow (w_underflow[r])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sb_err <= 1'b0;
      end else if (|w_underflow) begin
         r_sb_err <= 1'b1;
      end
   end

   assign o_sb_err = r_sb_err;

endmodule
`default_nettype wire

// File: tb/tb_rvv_backend_dispatch_sb_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_rvv_backend_dispatch_sb_ctrl
// Brief   : Directed plus randomized bench against a counting reference model.
// Rev     : 1.0
// ============================================================================
module tb_rvv_backend_dispatch_sb_ctrl;
   import rvv_backend_dispatch_sb_ctrl_pkg::*;

   localparam int MAXC = 7;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 i_flush = 1'b0;
   logic [1:0]           i_disp_valid = '0;
   SB_UOP_t [1:0]        i_disp_uop;
   logic [1:0]           o_disp_ready;
   logic [3:0]           i_retire_valid = '0;
   logic [3:0][4:0]      i_retire_vd_index;
   logic [31:0]          o_pending_mask;
   logic                 o_sb_err;

   int n_chk = 0;
   int n_err = 0;
   int m_cnt [32];
   bit m_err = 1'b0;

   always #5 clk = ~clk;

   rvv_backend_dispatch_sb_ctrl #(
      .DISP_NUM   (2),
      .RETIRE_NUM (4),
      .CNT_W      (3)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .i_flush           (i_flush),
      .i_disp_valid      (i_disp_valid),
      .i_disp_uop        (i_disp_uop),
      .o_disp_ready      (o_disp_ready),
      .i_retire_valid    (i_retire_valid),
      .i_retire_vd_index (i_retire_vd_index),
      .o_pending_mask    (o_pending_mask),
      .o_sb_err          (o_sb_err)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic bit needs(input SB_UOP_t u, input int r);
      return (u.vs1_valid && int'(u.vs1_index) == r) ||
             (u.vs2_valid && int'(u.vs2_index) == r) ||
             (u.vs3_valid && int'(u.vd_index)  == r) ||
             (!u.vm && r == 0);
   endfunction

   function automatic SB_UOP_t nop();
      SB_UOP_t u;
      u    = '0;
      u.vm = 1'b1;
      return u;
   endfunction

   function automatic SB_UOP_t wr(input int vd);
      SB_UOP_t u;
      u          = nop();
      u.vd_index = 5'(vd);
      u.vd_valid = 1'b1;
      return u;
   endfunction

   function automatic SB_UOP_t rd(input int s);
      SB_UOP_t u;
      u           = nop();
      u.vs2_index = 5'(s);
      u.vs2_valid = 1'b1;
      return u;
   endfunction

   function automatic logic [3:0][4:0] one(input int a);
      logic [3:0][4:0] r;
      r    = '0;
      r[0] = 5'(a);
      return r;
   endfunction

   // Applies one cycle of inputs, checks outputs against the model, advances the model.
   task automatic step(input logic [1:0] v, input SB_UOP_t u0, input SB_UOP_t u1,
                       input logic [3:0] rv, input logic [3:0][4:0] ri, input logic fl,
                       output logic [1:0] rdy);
      SB_UOP_t     u [2];
      int          eff [32];
      logic [1:0]  exp_rdy;
      logic [31:0] exp_pm;
      bit          prev, haz, sat;
      int          older;
      u[0] = u0;
      u[1] = u1;
      i_disp_valid      = v;
      i_disp_uop[0]     = u0;
      i_disp_uop[1]     = u1;
      i_retire_valid    = rv;
      i_retire_vd_index = ri;
      i_flush           = fl;
      #1;
      for (int r = 0; r < 32; r++) begin
         eff[r]    = m_cnt[r];
         exp_pm[r] = (m_cnt[r] != 0);
      end
`ifdef RVV_SB_RETIRE_BYPASS_EN
      if (!fl) begin
         for (int k = 0; k < 4; k++) if (rv[k]) eff[ri[k]]--;
      end
      for (int r = 0; r < 32; r++) if (eff[r] < 0) eff[r] = 0;
`endif
      prev = 1'b1;
      for (int i = 0; i < 2; i++) begin
         haz = 1'b0;
         for (int r = 0; r < 32; r++) if (needs(u[i], r) && eff[r] > 0) haz = 1'b1;
         older = 0;
         for (int j = 0; j < i; j++) begin
            if (v[j] && u[j].vd_valid) begin
               if (needs(u[i], int'(u[j].vd_index))) haz = 1'b1;
               if (u[j].vd_index == u[i].vd_index) older++;
            end
         end
         sat        = u[i].vd_valid && (eff[u[i].vd_index] + older >= MAXC);
         exp_rdy[i] = !fl && !haz && !sat && prev;
         prev       = exp_rdy[i];
      end
      rdy = o_disp_ready;
      check("disp_ready", 64'(o_disp_ready), 64'(exp_rdy));
      check("pending_mask", 64'(o_pending_mask), 64'(exp_pm));
      check("sb_err", 64'(o_sb_err), 64'(m_err));
      if (fl) begin
         for (int r = 0; r < 32; r++) m_cnt[r] = 0;
      end else begin
         for (int i = 0; i < 2; i++)
            if (v[i] && exp_rdy[i] && u[i].vd_valid) m_cnt[u[i].vd_index]++;
         for (int k = 0; k < 4; k++) if (rv[k]) m_cnt[ri[k]]--;
         for (int r = 0; r < 32; r++) begin
            if (m_cnt[r] < 0) begin
               m_cnt[r] = 0;
               m_err    = 1'b1;
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic mid_reset(input string tag);
      #2;
      rst = 1'b1;
      #1;
      check({tag, "_pm"}, 64'(o_pending_mask), 64'd0);
      check({tag, "_err"}, 64'(o_sb_err), 64'd0);
      for (int r = 0; r < 32; r++) m_cnt[r] = 0;
      m_err = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic [1:0]      g;
      SB_UOP_t         m, a, b;
      logic [1:0]      v;
      logic [3:0]      rv;
      logic [3:0][4:0] ri;
      logic            fl;
      int              tmp [32];
      int              cand [$];
      int              idx;
      bit              heavy;

      for (int r = 0; r < 32; r++) m_cnt[r] = 0;
      i_disp_uop[0]     = nop();
      i_disp_uop[1]     = nop();
      i_retire_vd_index = '0;
      #12;
      check("reset_pm", 64'(o_pending_mask), 64'd0);
      check("reset_err", 64'(o_sb_err), 64'd0);
      check("reset_ready", 64'(o_disp_ready), 64'd3);
      @(negedge clk);
      rst = 1'b0;

      // Writer then reader of v5, released by retire.
      step(2'b01, wr(5), nop(), 4'b0, '0, 1'b0, g);
      check("t1_accept", 64'(g), 64'd3);
      step(2'b01, rd(5), nop(), 4'b0, '0, 1'b0, g);
      check("t1_raw", 64'(g[0]), 64'd0);
      step(2'b01, rd(5), nop(), 4'b0001, one(5), 1'b0, g);
`ifdef RVV_SB_RETIRE_BYPASS_EN
      check("t1_retire_cycle", 64'(g[0]), 64'd1);
`else
      check("t1_retire_cycle", 64'(g[0]), 64'd0);
`endif
      step(2'b01, rd(5), nop(), 4'b0, '0, 1'b0, g);
      check("t1_release", 64'(g[0]), 64'd1);

      // Intra-group RAW.
      step(2'b11, wr(3), rd(3), 4'b0, '0, 1'b0, g);
      check("t2_intra", 64'(g), 64'd1);
      step(2'b01, rd(3), nop(), 4'b0001, one(3), 1'b0, g);
      step(2'b01, rd(3), nop(), 4'b0, '0, 1'b0, g);
      check("t2_after", 64'(g[0]), 64'd1);

      // v0 mask hazard blocks slot 0, so slot 1 must wait too.
      step(2'b01, wr(0), nop(), 4'b0, '0, 1'b0, g);
      m    = nop();
      m.vm = 1'b0;
      step(2'b11, m, wr(20), 4'b0, '0, 1'b0, g);
      check("t3_inorder", 64'(g), 64'd0);
      step(2'b00, nop(), nop(), 4'b0001, one(0), 1'b0, g);

      // Saturation on v9.
      for (int k = 0; k < 7; k++) begin
         step(2'b01, wr(9), nop(), 4'b0, '0, 1'b0, g);
         check("t4_fill", 64'(g[0]), 64'd1);
      end
      step(2'b01, wr(9), nop(), 4'b0, '0, 1'b0, g);
      check("t4_sat", 64'(g[0]), 64'd0);
      step(2'b01, wr(9), nop(), 4'b0001, one(9), 1'b0, g);
`ifndef RVV_SB_RETIRE_BYPASS_EN
      check("t4_sat_retire", 64'(g[0]), 64'd0);
      step(2'b01, wr(9), nop(), 4'b0, '0, 1'b0, g);
`endif
      check("t4_release", 64'(g[0]), 64'd1);
      for (int k = 0; k < 7; k++) begin
         check("t4_still_pending", 64'(o_pending_mask[9]), 64'd1);
         step(2'b00, nop(), nop(), 4'b0001, one(9), 1'b0, g);
      end
      check("t4_drained", 64'(o_pending_mask[9]), 64'd0);

      // Underflow is sticky across flush.
      step(2'b00, nop(), nop(), 4'b0001, one(4), 1'b0, g);
      check("t5_err", 64'(o_sb_err), 64'd1);
      step(2'b00, nop(), nop(), 4'b0, '0, 1'b1, g);
      check("t5_err_kept", 64'(o_sb_err), 64'd1);

      // Flush with pending vregs, concurrent retire and offered accept.
      step(2'b11, wr(1), wr(2), 4'b0, '0, 1'b0, g);
      check("t6_pair", 64'(g), 64'd3);
      step(2'b01, wr(6), nop(), 4'b0, '0, 1'b0, g);
      step(2'b01, wr(7), nop(), 4'b0001, one(1), 1'b1, g);
      check("t6_flush_ready", 64'(g), 64'd0);
      check("t6_flush_pm", 64'(o_pending_mask), 64'd0);

      step(2'b11, wr(10), wr(11), 4'b0, '0, 1'b0, g);
      mid_reset("rst1");

      for (int c = 0; c < 3000; c++) begin
         heavy = ((c / 150) % 2) == 0;
         a = '0;
         b = '0;
         a.vs1_index = 5'($urandom_range(0, 7));
         a.vs2_index = 5'($urandom_range(0, 7));
         a.vd_index  = 5'($urandom_range(0, 7));
         a.vs1_valid = 1'($urandom_range(0, 1));
         a.vs2_valid = 1'($urandom_range(0, 1));
         a.vs3_valid = ($urandom_range(0, 3) == 0);
         a.vm        = ($urandom_range(0, 4) != 0);
         a.vd_valid  = ($urandom_range(0, 9) < 7);
         b.vs1_index = 5'($urandom_range(0, 7));
         b.vs2_index = 5'($urandom_range(0, 7));
         b.vd_index  = 5'($urandom_range(0, 7));
         b.vs1_valid = 1'($urandom_range(0, 1));
         b.vs2_valid = 1'($urandom_range(0, 1));
         b.vs3_valid = ($urandom_range(0, 3) == 0);
         b.vm        = ($urandom_range(0, 4) != 0);
         b.vd_valid  = ($urandom_range(0, 9) < 7);
         v  = 2'($urandom_range(0, 3));
         fl = ($urandom_range(0, 99) == 0);
         tmp = m_cnt;
         rv  = '0;
         ri  = '0;
         for (int k = 0; k < 4; k++) begin
            if ($urandom_range(0, 99) < (heavy ? 15 : 60)) begin
               if ($urandom_range(0, 299) == 0) begin
                  rv[k] = 1'b1;
                  ri[k] = 5'($urandom_range(0, 31));
               end else begin
                  cand.delete();
                  for (int r = 0; r < 32; r++) if (tmp[r] > 0) cand.push_back(r);
                  if (cand.size() > 0) begin
                     idx = cand[$urandom_range(0, cand.size() - 1)];
                     rv[k] = 1'b1;
                     ri[k] = 5'(idx);
                     tmp[idx]--;
                  end
               end
            end
         end
         step(v, a, b, rv, ri, fl, g);
      end

      mid_reset("rst2");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
